// File: rtl/timer_arb_pkg.sv
// Shared types and constants for the timer slot arbiter.
// State encoding for the slot sequencer, the timer register map seen
// through the slot, and a small modulo-increment helper for the
// round-robin pointer.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic [7:0] TMR_COUNTER = 8'h00;
  localparam logic [7:0] TMR_ARR     = 8'h04;
  localparam logic [7:0] TMR_CTRL    = 8'h08;
  localparam logic [7:0] TMR_EG      = 8'h0C;
  localparam logic [7:0] TMR_STATUS  = 8'h10;

  // (v + 1) mod n, with n >= 1; a single requester always wraps to 0.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    int unsigned nxt;
    nxt = v + 1;
    if (nxt >= n) begin
      nxt = 0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/timer_slot_arbiter_rr_arbiter.sv
// Round-robin arbiter: holds the search pointer and produces a one-hot
// grant for the first active request at or after the pointer. The pointer
// moves past the winner only when the owner strobes advance.
module rr_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_req
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  int unsigned      cand;

  // Rotating priority search starting at the pointer.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + 32'(k);
      if (cand >= 32'(NUM_REQ)) begin
        cand = cand - 32'(NUM_REQ);
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        win_idx     = IDX_W'(cand);
      end
    end
    any_req = found;
  end

  // Next pointer: one past the winner when a grant is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = IDX_W'(wrap_inc(32'(win_idx), 32'(NUM_REQ)));
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/timer_slot_arbiter.sv
// Timer slot arbiter: shares one timer MMIO slot between NUM_REQ
// requesters, sequences the slot handshake and routes the response back
// to the granted requester.
// Optional build macro TIMER_ARB_TIMEOUT_EN adds an ISSUE-state cycle
// limit that aborts a stuck transaction with resp_timeout.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | slot free; grant the round-robin winner and latch its request
//   ISSUE | chip_select with read/write held until rd_done|wr_done
//   RESP  | one-cycle transaction_completed + resp_valid to the owner
module timer_slot_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_slave_error,
  output logic                      resp_decode_error,
  output logic                      resp_timeout,
  output logic                      busy,
  output logic                      chip_select,
  output logic                      read,
  output logic                      write,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      transaction_completed,
  input  logic [DATA_W-1:0]         rd_data,
  input  logic                      wr_done,
  input  logic                      rd_done,
  input  logic                      slave_error,
  input  logic                      decode_error
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;
  logic               advance;
  logic               slot_done;

  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;

  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               serr_q, serr_d;
  logic               derr_q, derr_d;

  logic               cs_q, cs_d;
  logic               rd_q, rd_d;
  logic               wr_en_q, wr_en_d;
  logic               tc_q, tc_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;

`ifdef TIMER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .any_req (any_req)
  );

  // Simultaneous rd_done and wr_done are one completion.
  assign slot_done = rd_done | wr_done;
  assign advance   = (state_q == IDLE) && any_req;

  // Next-state, request latch and response capture.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    serr_d  = serr_q;
    derr_d  = derr_q;
`ifdef TIMER_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = tout_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              wr_d    = req_write[i];
              addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
`ifdef TIMER_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef TIMER_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (slot_done) begin
          rdata_d = wr_q ? '0 : rd_data;
          serr_d  = slave_error;
          derr_d  = decode_error;
`ifdef TIMER_ARB_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef TIMER_ARB_TIMEOUT_EN
        // A done on the terminal-count cycle takes priority over the abort.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          serr_d  = 1'b1;
          derr_d  = 1'b0;
          tout_d  = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slot and response strobes are decoded from the next state so they
  // come straight out of flops.
  always_comb begin
    cs_d    = (state_d == ISSUE);
    rd_d    = cs_d && !wr_d;
    wr_en_d = cs_d && wr_d;
    tc_d    = (state_d == RESP);
    rv_d    = (state_d == RESP) ? owner_d : '0;
  end

  // State, request latch, slot controls and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= '0;
      rdata_q <= '0;
      serr_q  <= 1'b0;
      derr_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_en_q <= 1'b0;
      tc_q    <= 1'b0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      serr_q  <= serr_d;
      derr_q  <= derr_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_en_q <= wr_en_d;
      tc_q    <= tc_d;
      rv_q    <= rv_d;
    end
  end

`ifdef TIMER_ARB_TIMEOUT_EN
  // ISSUE cycle counter and timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign resp_timeout = tout_q;
`else
  assign resp_timeout = 1'b0;
`endif

  // Acceptance is the live grant while the slot is free; held low in reset.
  assign req_ready             = (state_q == IDLE && !rst) ? grant : '0;
  assign resp_valid            = rv_q;
  assign resp_rdata            = rdata_q;
  assign resp_slave_error      = serr_q;
  assign resp_decode_error     = derr_q;
  assign busy                  = (state_q != IDLE);
  assign chip_select           = cs_q;
  assign read                  = rd_q;
  assign write                 = wr_en_q;
  assign addr                  = addr_q;
  assign wr_data               = wdata_q;
  assign transaction_completed = tc_q;

endmodule

// File: tb/tb_timer_slot_arbiter.sv
// Self-checking bench for timer_slot_arbiter with a small timer slot model.
// Stimulus pushes expected grants/responses; a negedge monitor checks them.
module tb_timer_slot_arbiter;
  import timer_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TO_CYC  = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_slave_error, resp_decode_error, resp_timeout;
  logic                      busy, chip_select, read, write;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      transaction_completed;
  logic [DATA_W-1:0]         rd_data;
  logic                      wr_done_s, rd_done_s, slave_error, decode_error;
  logic                      stray, mute;

  timer_slot_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_slave_error(resp_slave_error), .resp_decode_error(resp_decode_error),
    .resp_timeout(resp_timeout), .busy(busy),
    .chip_select(chip_select), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
    .transaction_completed(transaction_completed), .rd_data(rd_data),
    .wr_done(wr_done_s | stray), .rd_done(rd_done_s | stray),
    .slave_error(slave_error), .decode_error(decode_error)
  );

  always #5 clk = ~clk;

  // ---------------- timer slot model ----------------
  logic [31:0] arr_r, ctrl_r, eg_r, cnt_r;
  int          cs_cnt;

  always @(posedge clk) begin
    rd_done_s    <= 1'b0;
    wr_done_s    <= 1'b0;
    slave_error  <= 1'b0;
    decode_error <= 1'b0;
    rd_data      <= '0;
    if (rst) begin
      cs_cnt <= 0;
      arr_r  <= '0;
      ctrl_r <= '0;
      eg_r   <= '0;
      cnt_r  <= '0;
    end else begin
      cnt_r  <= cnt_r + 1;
      cs_cnt <= chip_select ? cs_cnt + 1 : 0;
      if (chip_select && cs_cnt == 1 && !mute) begin
        if (write) begin
          wr_done_s <= 1'b1;
          case (addr)
            TMR_ARR:     arr_r  <= wr_data;
            TMR_CTRL:    ctrl_r <= wr_data;
            TMR_EG:      eg_r   <= wr_data;
            TMR_COUNTER: slave_error <= 1'b1;
            TMR_STATUS:  slave_error <= 1'b1;
            default:     decode_error <= 1'b1;
          endcase
        end else begin
          rd_done_s <= 1'b1;
          case (addr)
            TMR_ARR:     rd_data <= arr_r;
            TMR_CTRL:    rd_data <= ctrl_r;
            TMR_EG:      rd_data <= eg_r;
            TMR_COUNTER: rd_data <= cnt_r;
            TMR_STATUS:  rd_data <= 32'h0;
            default:     decode_error <= 1'b1;
          endcase
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        serr;
    logic        derr;
    logic        tout;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   grant_cyc = 0;
  int   cs_cycles = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic expect_txn(input int owner, input logic [31:0] rdata, input logic serr,
                            input logic derr, input logic tout, input int lat);
    exp_t e;
    e.owner = owner; e.rdata = rdata; e.serr = serr; e.derr = derr; e.tout = tout; e.lat = lat;
    grant_q.push_back(owner);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grants, responses, latency and chip_select window.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] onehot;
    exp_t e;
    int g;
    if (rst) begin
      cs_cycles = 0;
    end else begin
      if (chip_select) cs_cycles++;
      if (req_ready != '0) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 64'(req_ready), 64'(0));
        end else begin
          g = grant_q.pop_front();
          onehot = '0;
          onehot[g] = 1'b1;
          check("grant", 64'(req_ready), 64'(onehot));
        end
        grant_cyc = cyc;
        cs_cycles = 0;
      end
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          onehot = '0;
          onehot[e.owner] = 1'b1;
          check("resp_owner", 64'(resp_valid), 64'(onehot));
          check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          check("resp_slave_error", 64'(resp_slave_error), 64'(e.serr));
          check("resp_decode_error", 64'(resp_decode_error), 64'(e.derr));
          check("resp_timeout", 64'(resp_timeout), 64'(e.tout));
          check("resp_tc", 64'(transaction_completed), 64'(1));
          check("resp_latency", 64'(cyc - grant_cyc), 64'(e.lat));
          check("cs_cycles", 64'(cs_cycles), 64'(e.lat - 1));
          check("cs_low_in_resp", 64'(chip_select), 64'(0));
        end
      end else if (transaction_completed) begin
        check("tc_without_resp", 64'(transaction_completed), 64'(0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold_req(input int i, input int n, input logic wr,
                          input logic [7:0] a, input logic [31:0] d);
    int seen = 0;
    int budget = 0;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    while (seen < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (req_ready[i]) seen++;
    end
    if (seen < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_wait[%0d]: got %0d grants, required %0d", i, seen, n);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while ((busy || exp_q.size() != 0) && budget < 200);
    if (busy || exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy=%0d pending=%0d, required 0/0", busy, exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_cs"}, 64'(chip_select), 64'(0));
    check({tag, "_read"}, 64'(read), 64'(0));
    check({tag, "_write"}, 64'(write), 64'(0));
    check({tag, "_addr"}, 64'(addr), 64'(0));
    check({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    check({tag, "_tc"}, 64'(transaction_completed), 64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rdata"}, 64'(resp_rdata), 64'(0));
    check({tag, "_serr"}, 64'(resp_slave_error), 64'(0));
    check({tag, "_derr"}, 64'(resp_decode_error), 64'(0));
    check({tag, "_tout"}, 64'(resp_timeout), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    stray = 1'b0; mute = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // write ARR, read it back
    expect_txn(0, 32'd0, 1'b0, 1'b0, 1'b0, 4);
    hold_req(0, 1, 1'b1, TMR_ARR, 32'd1000);
    wait_idle();
    expect_txn(0, 32'd1000, 1'b0, 1'b0, 1'b0, 4);
    hold_req(0, 1, 1'b0, TMR_ARR, 32'd0);
    wait_idle();

    // write to the read-only counter (pointer 1 -> req1 -> pointer 0)
    expect_txn(1, 32'd0, 1'b1, 1'b0, 1'b0, 4);
    hold_req(1, 1, 1'b1, TMR_COUNTER, 32'h1234);
    wait_idle();

    // unmapped read (pointer 0 -> req0 -> pointer 1)
    expect_txn(0, 32'd0, 1'b0, 1'b1, 1'b0, 4);
    hold_req(0, 1, 1'b0, 8'h14, 32'd0);
    wait_idle();

    // set CTRL (req1 -> pointer 0)
    expect_txn(1, 32'd0, 1'b0, 1'b0, 1'b0, 4);
    hold_req(1, 1, 1'b1, TMR_CTRL, 32'hA5);
    wait_idle();

    // stray done pulses in IDLE, both at once, are ignored
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    @(negedge clk);
    check("stray_done_busy", 64'(busy), 64'(0));
    check("stray_done_cs", 64'(chip_select), 64'(0));

    // both requesters continuously valid: 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      expect_txn(0, 32'hA5, 1'b0, 1'b0, 1'b0, 4);
      expect_txn(1, 32'hA5, 1'b0, 1'b0, 1'b0, 4);
    end
    fork
      hold_req(0, 2, 1'b0, TMR_CTRL, 32'd0);
      hold_req(1, 2, 1'b0, TMR_CTRL, 32'd0);
    join
    wait_idle();

    // slot never answers
    mute = 1'b1;
`ifdef TIMER_ARB_TIMEOUT_EN
    expect_txn(0, 32'd0, 1'b1, 1'b0, 1'b1, TO_CYC + 1);
    hold_req(0, 1, 1'b0, TMR_ARR, 32'd0);
    wait_idle();
    grant_q.push_back(0);
    hold_req(0, 1, 1'b0, TMR_ARR, 32'd0);
`else
    grant_q.push_back(0);
    hold_req(0, 1, 1'b0, TMR_ARR, 32'd0);
    repeat (20) @(negedge clk);
    check("hang_busy", 64'(busy), 64'(1));
`endif
    @(negedge clk);
    check("pre_reset_cs", 64'(chip_select), 64'(1));

    // reset during ISSUE aborts with no response
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("abort");
    @(posedge clk); #1 rst = 1'b0;
    mute = 1'b0;

    // pointer back at 0: req0 write wins over req1 read of the same reg
    expect_txn(0, 32'd0, 1'b0, 1'b0, 1'b0, 4);
    expect_txn(1, 32'd77, 1'b0, 1'b0, 1'b0, 4);
    fork
      hold_req(0, 1, 1'b1, TMR_ARR, 32'd77);
      hold_req(1, 1, 1'b0, TMR_ARR, 32'd0);
    join
    wait_idle();
    repeat (3) @(negedge clk);

    check("pending_resps", 64'(exp_q.size()), 64'(0));
    check("pending_grants", 64'(grant_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
